sram_dp_param: RTL and testbench
================================

SRAM_DP_PARAM -- requirements
Module: sram_dp_param

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of words; power of two, >= 4.
REQ-002 SHALL have parameter WIDTH, default 36, bits per word.
REQ-003 SHALL have parameter OUT_REG, default 0, 0 = 1-cycle read latency, 1 = extra output register stage (2-cycle latency).
REQ-004 SHALL derive local AW = $clog2(DEPTH).
REQ-005 SHALL have ports:
  clk        input   1      single clock; all logic rising-edge
  rst_n      input   1      reset, synchronous, active-low
  we         input   1      write request
  waddr      input   AW     write address
  wdata      input   WIDTH  write data
  wmask      input   WIDTH  per-bit write enable, 1 = bit written
  re         input   1      read request
  raddr      input   AW     read address
  rdata      output  WIDTH  read data
  rvalid     output  1      rdata carries the result of a read this cycle
  init_busy  output  1      post-reset clear sequence in progress

Function
REQ-006 Storage SHALL be a DEPTH x WIDTH simple dual-port array: one write port, one read port, same clock.
REQ-007 FSM states SHALL be INIT and RUN; reset enters INIT with clear counter = 0.
REQ-008 In INIT, SHALL write all-zero to address = counter each cycle, counter += 1; init_busy = 1.
REQ-009 INIT -> RUN SHALL occur on the cycle after address DEPTH-1 is cleared; init_busy = 0 from that cycle; INIT lasts exactly DEPTH cycles.
REQ-010 In INIT, we and re SHALL be ignored: no user write, no read issued, rvalid = 0.
REQ-011 In RUN, we = 1 SHALL update mem[waddr] bits where wmask = 1; other bits keep old value; we = 1 with wmask = 0 leaves word unchanged.
REQ-012 In RUN, re = 1 SHALL issue a read; OUT_REG = 0: rdata/rvalid valid at cycle N+1; OUT_REG = 1: at N+2.
REQ-013 Back-to-back reads SHALL be accepted every cycle with no bubbles; rvalid follows re delayed by the latency.
REQ-014 Same-cycle read and write to the same address SHALL be write-first: returned word = (wdata AND wmask) OR (old AND NOT wmask).
REQ-015 A write in a later cycle than the read issue SHALL NOT alter that read's returned data, even if it lands before the result is presented.
REQ-016 Different-address simultaneous read/write SHALL be independent.
REQ-017 rdata SHALL hold its last value when rvalid = 0, with no change until the next valid result.
REQ-018 Addresses SHALL be AW bits wide, so every address is in range; no wrap logic beyond the AW-bit clear counter.
REQ-019 Combinational path from inputs to rdata/rvalid SHALL NOT exist.

Reset
REQ-020 While rst_n = 0 at a clock edge: state = INIT, counter = 0, init_busy = 1, rvalid = 0, rdata = 0, all pipeline valids = 0.
REQ-021 Reset asserted mid-RUN or mid-INIT SHALL discard in-flight reads (no rvalid for them) and restart the full clear from address 0.
REQ-022 Array contents are not reset directly; they are zero only through the INIT sequence.

Verification
REQ-023 DEPTH=16, WIDTH=36, OUT_REG=0: release rst_n -> init_busy high exactly 16 cycles; reads of all 16 addresses then return 36'h0.
REQ-024 RUN: write addr 3 = 36'hA_5A5A_5A5A with full mask, then mask 36'h0_0000_FFFF with data 36'hF_FFFF_1234 -> read addr 3 returns 36'hA_5A5A_1234 at N+1.
REQ-025 Same cycle: we to addr 5 = 36'h1_2345_6789, full mask, and re addr 5 (old 0) -> rdata = 36'h1_2345_6789; then write addr 5 = 0 one cycle after read issue with OUT_REG=1 -> read still returns 36'h1_2345_6789 at N+2.
REQ-026 OUT_REG=1: re on 4 consecutive cycles, addr 0..3 -> rvalid high cycles N+2..N+5, data in order, no gaps.
REQ-027 re and we asserted during INIT -> rvalid stays 0; addr written with 36'hF_FFFF_FFFF during INIT reads 0 after INIT.
REQ-028 Reset pulsed with 2 reads in flight (OUT_REG=1) -> no rvalid for them; init_busy high 16 cycles; previously written data reads back 0.

Source files
------------

// File: rtl/sram_dp_param.sv
// Simple dual-port SRAM with per-bit write mask, write-first collision handling,
// optional output register and a post-reset sequencer that zeroes every word.
module sram_dp_param #(
    parameter int DEPTH   = 1024,
    parameter int WIDTH   = 36,
    parameter int OUT_REG = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [WIDTH-1:0]           wmask,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]           rdata,
    output logic                       rvalid,
    output logic                       init_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] CNT_ONE   = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [AW-1:0]    clr_cnt_r;
    logic             clr_en_s;
    logic             wr_en_s;
    logic             rd_en_s;
    logic             init_busy_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_word_s;
    logic [WIDTH-1:0] s1_data_r;
    logic             s1_valid_r;

    // Bits with mask=1 take the new value, the rest keep the old word.
    function automatic logic [WIDTH-1:0] mask_merge(
        input logic [WIDTH-1:0] old_word,
        input logic [WIDTH-1:0] new_word,
        input logic [WIDTH-1:0] mask
    );
        return (new_word & mask) | (old_word & ~mask);
    endfunction

    // State register: reset always restarts the clear sequence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: leave INIT right after the last address is cleared.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (clr_cnt_r == LAST_ADDR) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_INIT;
                end
            end
            ST_RUN:  state_nx_s = ST_RUN;
            default: state_nx_s = ST_INIT;
        endcase
    end

    // Output decode: user traffic only in RUN, clearing only in INIT.
    always_comb begin
        clr_en_s = 1'b0;
        wr_en_s  = 1'b0;
        rd_en_s  = 1'b0;
        case (state_r)
            ST_INIT: clr_en_s = rst_n;
            ST_RUN: begin
                wr_en_s = rst_n & we;
                rd_en_s = rst_n & re;
            end
            default: begin
                clr_en_s = 1'b0;
                wr_en_s  = 1'b0;
                rd_en_s  = 1'b0;
            end
        endcase
    end

    // Clear counter and busy flag; busy drops on the first RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_cnt_r   <= {AW{1'b0}};
            init_busy_r <= 1'b1;
        end else begin
            if (clr_en_s) begin
                clr_cnt_r <= clr_cnt_r + CNT_ONE;
            end else begin
                clr_cnt_r <= clr_cnt_r;
            end
            init_busy_r <= (state_nx_s == ST_INIT);
        end
    end

    // Storage array: contents are only ever zeroed by the clear sequence.
    always_ff @(posedge clk) begin
        if (clr_en_s) begin
            mem_r[clr_cnt_r] <= {WIDTH{1'b0}};
        end else if (wr_en_s) begin
            mem_r[waddr] <= mask_merge(mem_r[waddr], wdata, wmask);
        end
    end

    // Write-first bypass so a same-address collision returns the merged word.
    always_comb begin
        if (wr_en_s && (waddr == raddr)) begin
            rd_word_s = mask_merge(mem_r[raddr], wdata, wmask);
        end else begin
            rd_word_s = mem_r[raddr];
        end
    end

    // First read stage: data is captured at issue, so later writes cannot leak in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {WIDTH{1'b0}};
        end else begin
            s1_valid_r <= rd_en_s;
            if (rd_en_s) begin
                s1_data_r <= rd_word_s;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] rdata_r;
            logic             rvalid_r;

            // Optional second stage; data holds whenever no result moves through.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rvalid_r <= 1'b0;
                    rdata_r  <= {WIDTH{1'b0}};
                end else begin
                    rvalid_r <= s1_valid_r;
                    if (s1_valid_r) begin
                        rdata_r <= s1_data_r;
                    end
                end
            end

            assign rdata  = rdata_r;
            assign rvalid = rvalid_r;
        end else begin : g_no_out_reg
            assign rdata  = s1_data_r;
            assign rvalid = s1_valid_r;
        end
    endgenerate

    assign init_busy = init_busy_r;

endmodule

// File: tb/tb_sram_dp_param.sv
// Scoreboard bench: one DUT per latency setting share the same stimulus; expected
// reads come from a bench memory model and are checked when each DUT presents them.
module tb_sram_dp_param;

    typedef struct {
        logic [35:0] d;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [3:0]  waddr = 4'd0;
    logic [3:0]  raddr = 4'd0;
    logic [35:0] wdata = 36'h0;
    logic [35:0] wmask = 36'h0;
    logic [35:0] rdata0, rdata1;
    logic        rvalid0, rvalid1, busy0, busy1;

    logic [35:0] model_m [16];
    logic [35:0] last0 = 36'h0;
    logic [35:0] last1 = 36'h0;
    exp_t        q0 [$];
    exp_t        q1 [$];
    int          cyc = 0;
    logic        rst_q = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    localparam logic [35:0] FULL = 36'hF_FFFF_FFFF;

    sram_dp_param #(.DEPTH(16), .WIDTH(36), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
        .re(re), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0), .init_busy(busy0)
    );

    sram_dp_param #(.DEPTH(16), .WIDTH(36), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
        .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .init_busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [35:0] merge(input logic [35:0] o, input logic [35:0] n,
                                          input logic [35:0] m);
        return (n & m) | (o & ~m);
    endfunction

    // Compare both DUT output ports against their scoreboards on the falling edge.
    always @(negedge clk) begin
        logic ev;
        exp_t e;
        if (cyc > 0) begin
            if (!rst_q) begin
                last0 = 36'h0;
                last1 = 36'h0;
            end
            ev = 1'b0;
            if (q0.size() > 0 && q0[0].due == cyc) begin
                ev = 1'b1;
                e  = q0.pop_front();
            end
            chk("rvalid_lat1", {35'h0, rvalid0}, {35'h0, ev});
            if (ev) begin
                chk("rdata_lat1", rdata0, e.d);
                last0 = e.d;
            end else begin
                chk("hold_lat1", rdata0, last0);
            end
            ev = 1'b0;
            if (q1.size() > 0 && q1[0].due == cyc) begin
                ev = 1'b1;
                e  = q1.pop_front();
            end
            chk("rvalid_lat2", {35'h0, rvalid1}, {35'h0, ev});
            if (ev) begin
                chk("rdata_lat2", rdata1, e.d);
                last1 = e.d;
            end else begin
                chk("hold_lat2", rdata1, last1);
            end
        end
    end

    // One RUN-phase cycle of stimulus; expectations are fixed at issue time.
    task automatic drv(input logic w, input int wa, input logic [35:0] wd,
                       input logic [35:0] wm, input logic r, input int ra);
        exp_t e;
        @(posedge clk);
        #1;
        we = w; waddr = 4'(wa); wdata = wd; wmask = wm;
        re = r; raddr = 4'(ra);
        if (r) begin
            if (w && (wa == ra)) e.d = merge(model_m[ra], wd, wm);
            else                 e.d = model_m[ra];
            e.due = cyc + 1;
            q0.push_back(e);
            e.due = cyc + 2;
            q1.push_back(e);
        end
        if (w) model_m[wa] = merge(model_m[wa], wd, wm);
    endtask

    // Assert reset now (discarding every read not yet due), then run the clear phase
    // while hammering we/re, which the DUT must ignore.
    task automatic do_reset();
        int n0, n1, guard;
        while (q0.size() > 0 && q0[q0.size()-1].due > cyc) void'(q0.pop_back());
        while (q1.size() > 0 && q1[q1.size()-1].due > cyc) void'(q1.pop_back());
        rst_n = 1'b0; we = 1'b0; re = 1'b0;
        for (int i = 0; i < 16; i++) model_m[i] = 36'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n0 = 0; n1 = 0; guard = 0;
        while ((busy0 || busy1) && guard < 40) begin
            guard++;
            if (busy0) n0++;
            if (busy1) n1++;
            we = 1'b1; waddr = 4'd7; wdata = FULL; wmask = FULL;
            re = 1'b1; raddr = 4'd7;
            @(posedge clk);
            #1;
        end
        we = 1'b0; re = 1'b0;
        chk("init_len_lat1", 36'(n0), 36'd16);
        chk("init_len_lat2", 36'(n1), 36'd16);
    endtask

    initial begin
        logic [63:0] r64;
        logic [63:0] m64;
        do_reset();

        for (int a = 0; a < 16; a++) drv(1'b0, 0, 36'h0, 36'h0, 1'b1, a);

        drv(1'b1, 3, 36'hA_5A5A_5A5A, FULL, 1'b0, 0);
        drv(1'b1, 3, 36'hF_FFFF_1234, 36'h0_0000_FFFF, 1'b0, 0);
        drv(1'b0, 0, 36'h0, 36'h0, 1'b1, 3);

        drv(1'b1, 5, 36'h1_2345_6789, FULL, 1'b1, 5);
        drv(1'b1, 5, 36'h0, FULL, 1'b0, 0);
        drv(1'b0, 0, 36'h0, 36'h0, 1'b1, 5);

        for (int a = 0; a < 4; a++) drv(1'b1, a, 36'(64'h1_0000_0011 * (a + 1)), FULL, 1'b0, 0);
        for (int a = 0; a < 4; a++) drv(1'b0, 0, 36'h0, 36'h0, 1'b1, a);
        drv(1'b1, 2, 36'hF_0F0F_0F0F, 36'h0, 1'b1, 2);
        drv(1'b1, 8, 36'h8_8888_8888, FULL, 1'b1, 3);
        drv(1'b0, 0, 36'h0, 36'h0, 1'b1, 8);
        drv(1'b0, 0, 36'h0, 36'h0, 1'b1, 7);

        for (int i = 0; i < 60; i++) begin
            r64 = {$urandom, $urandom};
            m64 = ($urandom_range(0, 3) == 0) ? 64'hF_FFFF_FFFF : {$urandom, $urandom};
            drv(1'($urandom_range(0, 1)), $urandom_range(0, 15), r64[35:0], m64[35:0],
                1'($urandom_range(0, 1)), $urandom_range(0, 15));
        end

        drv(1'b1, 9, 36'h3_3333_3333, FULL, 1'b0, 0);
        drv(1'b1, 2, 36'hC_CCCC_CCCC, FULL, 1'b0, 0);
        drv(1'b0, 0, 36'h0, 36'h0, 1'b1, 9);
        drv(1'b0, 0, 36'h0, 36'h0, 1'b1, 2);
        do_reset();
        drv(1'b0, 0, 36'h0, 36'h0, 1'b1, 9);
        drv(1'b0, 0, 36'h0, 36'h0, 1'b1, 2);
        drv(1'b0, 0, 36'h0, 36'h0, 1'b1, 7);

        repeat (4) drv(1'b0, 0, 36'h0, 36'h0, 1'b0, 0);
        @(posedge clk);
        #1;
        chk("drain_lat1", 36'(q0.size()), 36'd0);
        chk("drain_lat2", 36'(q1.size()), 36'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
